// File: rtl/aes_ctr_ctrl_pkg.sv
// aes_pkg -- shared definitions for the AES-CTR controller.
// Ports: none (package). Provides the controller state enum, the prefetch
// tracker enum, the AES block width and the counter-increment helper.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  // Cycles aes_ready_i may stay high after a start pulse before it is
  // assumed the engine missed the pulse.
  localparam int unsigned TIMEOUT_CYCLES = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, XOR, OUT} state_t;

  typedef enum logic [1:0] {PF_NONE, PF_WAIT_BUSY, PF_WAIT_DONE, PF_READY} pf_state_t;

  // Adds one to the low 'width' bits modulo 2^width; upper bits untouched.
  function automatic logic [AES_BLK_W-1:0] ctr_inc(input logic [AES_BLK_W-1:0] ctr,
                                                    input int unsigned width);
    logic [AES_BLK_W-1:0] mask;
    if (width >= AES_BLK_W) mask = '1;
    else mask = (AES_BLK_W'(1) << width) - AES_BLK_W'(1);
    return (ctr & ~mask) | ((ctr + AES_BLK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// aes_ctr_ctrl_if -- data stream bundle of the AES-CTR controller.
// Input side:  s_data, s_valid, s_last (to controller), s_ready (from it).
// Output side: m_data, m_valid, m_last (from controller), m_ready (to it).
// Modports: slave = the controller, master = the producer/consumer around it.
interface aes_ctr_ctrl_if;
  import aes_pkg::*;

  logic [AES_BLK_W-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [AES_BLK_W-1:0] m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_ready;

  modport slave  (input  s_data, s_valid, s_last, m_ready,
                  output s_ready, m_data, m_valid, m_last);
  modport master (output s_data, s_valid, s_last, m_ready,
                  input  s_ready, m_data, m_valid, m_last);
endinterface

// File: rtl/aes_ctr_ctrl.sv
// aes_ctr_ctrl -- AES-CTR mode controller around an external aes_enc core.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cfg_iv, cfg_start  initial counter block and message start pulse
//   strm (slave)       s_* input blocks, m_* output blocks (s_data ^ keystream)
//   aes_block_o/aes_valid_o  counter block and start pulse to aes_enc
//   aes_ready_i/aes_block_i  aes_enc idle/done flag and keystream result
//   busy, blk_count    message in progress, blocks output (saturating)
// Optional macro AES_CTR_PREFETCH_EN: fetch the next keystream while OUT
// waits for m_ready.
module aes_ctr_ctrl
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int BLK_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLK_WIDTH-1:0] cfg_iv,
  input  logic                 cfg_start,
  aes_ctr_ctrl_if.slave        strm,
  output logic [BLK_WIDTH-1:0] aes_block_o,
  output logic                 aes_valid_o,
  input  logic                 aes_ready_i,
  input  logic [BLK_WIDTH-1:0] aes_block_i,
  output logic                 busy,
  output logic [31:0]          blk_count
);

  if (BLK_WIDTH != AES_BLK_W) begin : g_bad_blk_width
    $error("aes_ctr_ctrl: BLK_WIDTH must be 128");
  end
  if (CTR_WIDTH < 8 || CTR_WIDTH > 128) begin : g_bad_ctr_width
    $error("aes_ctr_ctrl: CTR_WIDTH must be within 8..128");
  end

  localparam int unsigned CTR_W_U = CTR_WIDTH;

  state_t               state_q, state_d;
  logic [BLK_WIDTH-1:0] ctr_q, ctr_d;
  logic [BLK_WIDTH-1:0] ks_q, ks_d;
  logic [BLK_WIDTH-1:0] m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic                 busy_q, busy_d;
  logic [31:0]          blk_count_q, blk_count_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic                 reissued_q, reissued_d;
  logic                 aes_valid, aes_valid_q;
`ifdef AES_CTR_PREFETCH_EN
  pf_state_t            pf_q, pf_d;
  logic [BLK_WIDTH-1:0] ks_next_q, ks_next_d;
`endif

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    ks_d        = ks_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    busy_d      = busy_q;
    blk_count_d = blk_count_q;
    wait_cnt_d  = wait_cnt_q;
    reissued_d  = reissued_q;
    aes_valid   = 1'b0;
`ifdef AES_CTR_PREFETCH_EN
    pf_d        = pf_q;
    ks_next_d   = ks_next_q;
`endif

    case (state_q)
      IDLE: ;
      // The aes_valid_q guard keeps start pulses apart even if the engine
      // still reports ready in the cycle right after a pulse.
      ISSUE: begin
        if (aes_ready_i && !aes_valid_q) begin
          aes_valid  = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT_BUSY;
        end
      end
      // A pulse the engine never reacted to is re-sent once; if it still
      // stays ready, it is treated as an instantly finished operation.
      WAIT_BUSY: begin
        if (!aes_ready_i) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == 2'(TIMEOUT_CYCLES - 1)) begin
          wait_cnt_d = '0;
          reissued_d = 1'b1;
          state_d    = reissued_q ? WAIT_DONE : ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (aes_ready_i) begin
          ks_d       = aes_block_i;
          ctr_d      = ctr_inc(ctr_q, CTR_W_U);
          reissued_d = 1'b0;
          state_d    = XOR;
        end
      end
      XOR: begin
        if (strm.s_valid) begin
          m_data_d = strm.s_data ^ ks_q;
          m_last_d = strm.s_last;
          state_d  = OUT;
        end
      end
      OUT: begin
`ifdef AES_CTR_PREFETCH_EN
        // ctr already points at the next block, so it can be sent now.
        case (pf_q)
          PF_NONE: begin
            if (!m_last_q && aes_ready_i && !aes_valid_q) begin
              aes_valid = 1'b1;
              pf_d      = PF_WAIT_BUSY;
            end
          end
          PF_WAIT_BUSY: if (!aes_ready_i) pf_d = PF_WAIT_DONE;
          PF_WAIT_DONE: begin
            if (aes_ready_i) begin
              ks_next_d = aes_block_i;
              ctr_d     = ctr_inc(ctr_q, CTR_W_U);
              pf_d      = PF_READY;
            end
          end
          default: ;
        endcase
`endif
        if (strm.m_ready) begin
          if (blk_count_q != '1) blk_count_d = blk_count_q + 32'd1;
          if (m_last_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
`ifdef AES_CTR_PREFETCH_EN
            // Hand an unfinished prefetch over to the main sequence.
            wait_cnt_d = '0;
            case (pf_d)
              PF_READY: begin
                ks_d    = ks_next_d;
                state_d = XOR;
              end
              PF_WAIT_DONE: state_d = WAIT_DONE;
              PF_WAIT_BUSY: state_d = WAIT_BUSY;
              default:      state_d = ISSUE;
            endcase
`else
            state_d = ISSUE;
`endif
          end
`ifdef AES_CTR_PREFETCH_EN
          pf_d = PF_NONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A new message wins in every state; any engine result still in flight
    // is overwritten by the next WAIT_DONE capture and never used.
    if (cfg_start) begin
      ctr_d       = cfg_iv;
      ks_d        = '0;
      blk_count_d = '0;
      busy_d      = 1'b1;
      wait_cnt_d  = '0;
      reissued_d  = 1'b0;
      aes_valid   = 1'b0;
      state_d     = ISSUE;
`ifdef AES_CTR_PREFETCH_EN
      pf_d        = PF_NONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      ks_q        <= '0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
      wait_cnt_q  <= '0;
      reissued_q  <= 1'b0;
      aes_valid_q <= 1'b0;
`ifdef AES_CTR_PREFETCH_EN
      pf_q        <= PF_NONE;
      ks_next_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      ks_q        <= ks_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      blk_count_q <= blk_count_d;
      wait_cnt_q  <= wait_cnt_d;
      reissued_q  <= reissued_d;
      aes_valid_q <= aes_valid;
`ifdef AES_CTR_PREFETCH_EN
      pf_q        <= pf_d;
      ks_next_q   <= ks_next_d;
`endif
    end
  end

  assign aes_block_o  = ctr_q;
  assign aes_valid_o  = aes_valid;
  assign strm.s_ready = (state_q == XOR);
  assign strm.m_valid = (state_q == OUT);
  assign strm.m_data  = m_data_q;
  assign strm.m_last  = m_last_q;
  assign busy         = busy_q;
  assign blk_count    = blk_count_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// tb_aes_ctr_ctrl -- self-checking bench for aes_ctr_ctrl.
// Contains a behavioural aes_enc stand-in whose keystream table holds the
// AES-128 outputs for key 2b7e151628aed2a6abf7158809cf4f3c at the NIST CTR
// counter blocks, and a message-level reference model for all other blocks.
module tb_aes_ctr_ctrl;
  import aes_pkg::*;

  localparam int BUDGET = 300;

  localparam logic [127:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] NIST_P0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] NIST_P1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] NIST_P2 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] NIST_P3 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] NIST_C0 = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] NIST_C1 = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] NIST_C2 = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
  localparam logic [127:0] NIST_C3 = 128'h1e031dda2fbe03d1792170a0f3009cee;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_start = 1'b0;
  logic [127:0] aes_block_o, aes_block_i;
  logic         aes_valid_o, aes_ready_i, busy;
  logic [31:0]  blk_count;

  int total = 0;
  int bad = 0;
  int issue_base = 0;

  aes_ctr_ctrl_if sif();

  aes_ctr_ctrl #(.CTR_WIDTH(32), .BLK_WIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_iv(cfg_iv), .cfg_start(cfg_start),
    .strm(sif.slave),
    .aes_block_o(aes_block_o), .aes_valid_o(aes_valid_o),
    .aes_ready_i(aes_ready_i), .aes_block_i(aes_block_i),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Keystream source: NIST vectors where known, otherwise a fixed mixing
  // function standing in for AES under the same key.
  function automatic logic [127:0] aes_ref(input logic [127:0] ctr_blk);
    case (ctr_blk)
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: return 128'h362b7c3c6773516318a077d7fc5073ae;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01: return 128'h6a2cc3787889374fbeb4c81b17ba6c44;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02: return 128'he89c399ff0f198c6d40a31db156cabfe;
      default: return {ctr_blk[63:0] ^ 64'h9e3779b97f4a7c15,
                       ctr_blk[127:64] ^ 64'hc2b2ae3d27d4eb4f} + 128'h1;
    endcase
  endfunction

  // Counter block of message block idx: low 32 bits wrap, upper 96 fixed.
  function automatic logic [127:0] exp_ctr(input logic [127:0] iv, input int idx);
    logic [31:0] low;
    low = iv[31:0] + 32'(idx);
    return {iv[127:32], low};
  endfunction

  // aes_enc stand-in: ready when idle, busy for aes_lat cycles per start.
  int           aes_busy_cnt = 0;
  int           aes_lat = 3;
  logic         aes_force_busy = 1'b0;
  logic [127:0] aes_pending = '0;
  logic [127:0] aes_out = '0;
  int           aes_pulses = 0;
  int           consec_pulses = 0;
  logic         prev_valid = 1'b0;
  logic [127:0] issued_q[$];

  assign aes_ready_i = (aes_busy_cnt == 0) && !aes_force_busy;
  assign aes_block_i = aes_out;

  always @(posedge clk) begin
    prev_valid <= aes_valid_o;
    if (aes_valid_o) aes_pulses <= aes_pulses + 1;
    if (aes_valid_o && prev_valid) consec_pulses <= consec_pulses + 1;
    if (aes_busy_cnt != 0) begin
      aes_busy_cnt <= aes_busy_cnt - 1;
      if (aes_busy_cnt == 1) aes_out <= aes_ref(aes_pending);
    end else if (aes_valid_o && aes_ready_i) begin
      aes_pending  <= aes_block_o;
      aes_busy_cnt <= aes_lat;
      issued_q.push_back(aes_block_o);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic startMessage(input logic [127:0] iv);
    cfg_iv    = iv;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    issue_base = issued_q.size();
  endtask

  // Offers one block, captures the result, optionally stalls m_ready.
  task automatic applyStimulus(input logic [127:0] data, input logic last, input int stall,
                               output logic [127:0] got, output logic got_last);
    int n;
    int stall_bad;
    int p0;
    got = '0;
    got_last = 1'b0;
    sif.s_data  = data;
    sif.s_last  = last;
    sif.s_valid = 1'b1;
    n = 0;
    while (sif.s_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (sif.s_ready !== 1'b1) begin
      sif.s_valid = 1'b0;
      checkOutput("s_ready_wait", sif.s_ready, 1'b1);
    end else begin
      @(negedge clk);
      sif.s_valid = 1'b0;
      checkOutput("latency_m_valid", sif.m_valid, 1'b1);
      got = sif.m_data;
      got_last = sif.m_last;
      stall_bad = 0;
      p0 = aes_pulses;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (sif.m_data !== got || sif.m_last !== got_last || sif.s_ready !== 1'b0 ||
            sif.m_valid !== 1'b1)
          stall_bad++;
      end
      if (stall > 0) begin
        checkOutput("stall_stable", stall_bad, 0);
`ifdef AES_CTR_PREFETCH_EN
        checkOutput("stall_aes_pulses", (aes_pulses - p0) <= (last ? 0 : 1), 1'b1);
`else
        checkOutput("stall_aes_pulses", aes_pulses - p0, 0);
`endif
      end
      sif.m_ready = 1'b1;
      @(negedge clk);
      sif.m_ready = 1'b0;
    end
  endtask

  // Random message checked against the reference model.
  task automatic runMessage(input logic [127:0] iv, input int nblk, input int max_stall);
    logic [127:0] pt, got, ctr_seen;
    logic gl;
    startMessage(iv);
    for (int i = 0; i < nblk; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(pt, i == nblk - 1, $urandom_range(max_stall, 0), got, gl);
      checkOutput($sformatf("rand_m_data_%0d", i), got, pt ^ aes_ref(exp_ctr(iv, i)));
      checkOutput($sformatf("rand_m_last_%0d", i), gl, i == nblk - 1);
    end
    checkOutput("rand_busy_end", busy, 1'b0);
    checkOutput("rand_blk_count", blk_count, nblk);
    checkOutput("rand_issue_count", issued_q.size() - issue_base, nblk);
    for (int i = 0; i < nblk && issue_base + i < issued_q.size(); i++) begin
      ctr_seen = issued_q[issue_base + i];
      checkOutput($sformatf("rand_ctr_%0d", i), ctr_seen, exp_ctr(iv, i));
    end
  endtask

  initial begin
    logic [127:0] got, iv, ctr_seen;
    logic gl;
    int n, p0;

    sif.s_data  = '0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.m_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_blk_count", blk_count, 0);
    checkOutput("rst_s_ready", sif.s_ready, 1'b0);
    checkOutput("rst_m_valid", sif.m_valid, 1'b0);
    checkOutput("rst_m_data", sif.m_data, '0);
    checkOutput("rst_m_last", sif.m_last, 1'b0);
    checkOutput("rst_aes_valid", aes_valid_o, 1'b0);
    checkOutput("rst_aes_block", aes_block_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] NIST message, first issue held off by a busy engine");
    aes_force_busy = 1'b1;
    p0 = aes_pulses;
    startMessage(NIST_IV);
    repeat (5) @(negedge clk);
    checkOutput("issue_waits_ready", aes_pulses - p0, 0);
    checkOutput("busy_after_start", busy, 1'b1);
    checkOutput("aes_block_is_iv", aes_block_o, NIST_IV);
    aes_force_busy = 1'b0;
    applyStimulus(NIST_P0, 1'b0, 0, got, gl);
    checkOutput("nist_blk0", got, NIST_C0);
    applyStimulus(NIST_P1, 1'b0, 10, got, gl);
    checkOutput("nist_blk1", got, NIST_C1);
    applyStimulus(NIST_P2, 1'b0, 0, got, gl);
    checkOutput("nist_blk2", got, NIST_C2);
    applyStimulus(NIST_P3, 1'b1, 0, got, gl);
    checkOutput("nist_blk3", got, NIST_C3);
    checkOutput("nist_last", gl, 1'b1);
    checkOutput("nist_busy_end", busy, 1'b0);
    checkOutput("nist_blk_count", blk_count, 4);

    $display("[TB] counter wrap of the low 32 bits");
    iv = {$urandom, $urandom, $urandom, 32'hffffffff};
    runMessage(iv, 2, 2);
    if (issued_q.size() >= issue_base + 2) begin
      ctr_seen = issued_q[issue_base + 1];
      checkOutput("wrap_low_zero", ctr_seen[31:0], 32'h0);
      checkOutput("wrap_upper_kept", ctr_seen[127:32], iv[127:32]);
    end else begin
      checkOutput("wrap_issue_count", issued_q.size() - issue_base, 2);
    end

    $display("[TB] random messages");
    for (int m = 0; m < 4; m++) begin
      aes_lat = $urandom_range(5, 1);
      runMessage({$urandom, $urandom, $urandom, $urandom}, $urandom_range(4, 1), 3);
    end

    $display("[TB] restart while waiting for the engine");
    aes_lat = 6;
    startMessage({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (aes_ready_i !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_engine_started", aes_ready_i, 1'b0);
    @(negedge clk);
    startMessage(NIST_IV);
    aes_lat = 3;
    applyStimulus(NIST_P0, 1'b1, 0, got, gl);
    checkOutput("abort_new_iv_m_data", got, NIST_C0);
    checkOutput("abort_blk_count", blk_count, 1);
    checkOutput("abort_busy_end", busy, 1'b0);

    $display("[TB] reset while a block waits in the output stage");
    startMessage({$urandom, $urandom, $urandom, $urandom});
    sif.s_data  = {$urandom, $urandom, $urandom, $urandom};
    sif.s_last  = 1'b0;
    sif.s_valid = 1'b1;
    n = 0;
    while (sif.s_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    checkOutput("pre_reset_m_valid", sif.m_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_m_valid", sif.m_valid, 1'b0);
    checkOutput("mid_rst_m_data", sif.m_data, '0);
    checkOutput("mid_rst_m_last", sif.m_last, 1'b0);
    checkOutput("mid_rst_s_ready", sif.s_ready, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_blk_count", blk_count, 0);
    checkOutput("mid_rst_aes_valid", aes_valid_o, 1'b0);
    checkOutput("mid_rst_aes_block", aes_block_o, '0);
    checkOutput("mid_rst_state", 128'(dut.state_q), 128'(IDLE));
    repeat (12) @(negedge clk);

    checkOutput("no_consecutive_aes_valid", consec_pulses, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
